rf_write_arbiter: RTL and testbench
===================================

Name: rf_write_arbiter

Overview:
- Shares the single register-file write port of the single-cycle core between NUM_REQ writeback sources (ALU result, load unit, CSR unit) using round-robin arbitration.
- Each requester uses a valid/ready handshake.
- The winning write is presented on a registered write port one cycle after acceptance.
- Writes to x0 are accepted and then discarded.
- After reset is released, the block holds off all grants for one cycle, so the port idles while the storage comes out of reset.

Parameters:
- NUM_REQ, 3, number of write requesters; legal range 2..8.
- XLEN, 32, data width of a register write.
- ADDR_W, 5, register index width (32 architectural registers).
- ID_W, $clog2(NUM_REQ), width of the source-id output (derived, not overridable).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset; one clock domain only.
- req_valid  input  NUM_REQ  per-requester write request; bit i belongs to requester i.
- req_addr  input  NUM_REQ*ADDR_W  destination index; slice i is [i*ADDR_W +: ADDR_W].
- req_data  input  NUM_REQ*XLEN  write data; slice i is [i*XLEN +: XLEN].
- req_ready  output  NUM_REQ  one-hot or zero grant; a handshake for requester i occurs when req_valid[i] and req_ready[i] are both high at a posedge.
- wr_en  output  1  registered register-file write enable.
- wr_addr  output  ADDR_W  registered write index.
- wr_data  output  XLEN  registered write data.
- wr_src  output  ID_W  registered index of the requester that produced the current wr_en.

Behaviour:
- Reset (rst=0, asynchronous):
  - wr_en=0, wr_addr=0, wr_data=0, wr_src=0.
  - rr_ptr=0.
  - state=HOLD.
  - req_ready forced to 0 combinationally.
- HOLD state:
  - Entered on reset.
  - req_ready=0 regardless of inputs.
  - The first posedge with rst=1 moves the block to RUN. No handshake can occur before the second posedge after reset release.
- RUN state; grant selection is combinational:
  - Scan req_valid starting at index rr_ptr, ascending, wrapping NUM_REQ-1 -> 0.
  - The first set bit gets req_ready=1; all other bits are 0.
  - If no request is valid, req_ready=0.
  - req_ready never depends on req_addr or req_data.
- On a handshake by requester g at posedge t:
  - At t+1: wr_en=(req_addr[g]!=0), wr_addr=req_addr[g], wr_data=req_data[g], wr_src=g.
  - rr_ptr <= (g+1) mod NUM_REQ.
- No handshake at posedge t:
  - wr_en <= 0 at t+1.
  - wr_addr, wr_data, wr_src and rr_ptr hold their values.
- x0 write: the request is consumed (ready asserted and the pointer advances), but wr_en stays 0. wr_addr, wr_data and wr_src still load, for debug visibility.
- Throughput and latency: one accepted write per cycle sustained; fixed latency of one cycle from handshake to wr_en.
- Requester obligations: hold valid, addr and data stable until the handshake. The arbiter never revokes req_ready within a cycle for a still-valid winner.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0,... No requester waits more than NUM_REQ-1 handshakes.
- Simultaneous events: a single-requester stream gets back-to-back grants, because the pointer wrap still finds it. No idle bubble is inserted between grants.
- Reset mid-operation:
  - A write on wr_en is cleared immediately.
  - Any in-flight request is not accepted.
  - Requesters keep valid high and are served after HOLD completes.
- There is no state other than HOLD and RUN. Illegal state encodings recover to HOLD.

Decomposition:
- Shared core package holds:
  - constants XLEN=32 and REG_ADDR_W=5;
  - the default writeback-source count and the source-id encoding (0=ALU, 1=LOAD, 2=CSR);
  - the arbiter state encoding (HOLD, RUN).
- One natural sub-module: rr_priority_pick.
  - Purely combinational.
  - Inputs: request vector and rotation pointer.
  - Outputs: one-hot grant and its binary index.
  - It is reused later by the memory-port arbiter.
- The register stage stays in rf_write_arbiter.

Test Plan:
1. Reset release: hold rst=0 with req_valid=3'b111, then release. Expect req_ready=0 on the first posedge after release; the first handshake at the second posedge is requester 0; at the next edge wr_en=1 and wr_src=0.
2. Round-robin, NUM_REQ=3: all valid, addrs 1/2/3, data 0xA/0xB/0xC. Expect wr_addr sequence 1,2,3,1,2,3 with wr_en=1 every cycle and no bubbles.
3. x0 suppression: requester 1 alone, addr=0, data=0xDEADBEEF. Expect req_ready[1]=1 and the handshake to complete; next cycle wr_en=0, wr_addr=0, wr_src=1; rr_ptr becomes 2.
4. Pointer skip/wrap: rr_ptr=2 and only requester 0 valid (addr=7, data=0x55). Expect a grant to 0, then wr_en=1, wr_addr=7, wr_data=0x55; rr_ptr becomes 1.
5. Idle hold: after a write to addr=9, drop all valids for 3 cycles. Expect wr_en=0 while wr_addr=9 and the data value hold unchanged.
6. Async reset mid-stream: assert rst=0 between edges while wr_en=1. Expect wr_en, wr_addr and req_ready to go to 0 immediately, before the next edge; after release, one HOLD cycle, then service resumes at requester 0.

Source files
------------

// File: rtl/rf_write_arbiter_pkg.sv
// Shared core constants for the writeback path: data/index widths, writeback
// source ids and the register-file write arbiter state encoding.
package rf_write_arbiter_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_WB_SRC = 3;

    typedef enum logic [1:0] {
        SRC_ALU  = 2'd0,
        SRC_LOAD = 2'd1,
        SRC_CSR  = 2'd2
    } wb_src_e;

    // Two-hot-free encoding leaves spare codes, which recover to HOLD.
    typedef enum logic [1:0] {
        HOLD = 2'b01,
        RUN  = 2'b10
    } arb_state_e;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating-priority picker: first set request at or after i_ptr
// (ascending, wrapping) wins. Shared by the RF write and memory-port arbiters.
module rr_priority_pick #(
    parameter int N   = 3,
    parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]   i_req,
    input  logic [IDW-1:0] i_ptr,
    output logic [N-1:0]   o_gnt,
    output logic [IDW-1:0] o_idx,
    output logic           o_any
);

    logic w_found;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!w_found && i_req[(int'(i_ptr) + k) % N]) begin
                w_found                       = 1'b1;
                o_gnt[(int'(i_ptr) + k) % N]  = 1'b1;
                o_idx                         = IDW'((int'(i_ptr) + k) % N);
            end
        end
    end

    assign o_any = w_found;

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port among writeback
// sources; the winning write appears on a registered port one cycle later.
module rf_write_arbiter #(
    parameter int NUM_REQ = rf_write_arbiter_pkg::NUM_WB_SRC,
    parameter int XLEN    = rf_write_arbiter_pkg::XLEN,
    parameter int ADDR_W  = rf_write_arbiter_pkg::REG_ADDR_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*XLEN-1:0]   req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [XLEN-1:0]           wr_data,
    output logic [$clog2(NUM_REQ)-1:0] wr_src
);
    import rf_write_arbiter_pkg::*;

    localparam int ID_W = $clog2(NUM_REQ);

    arb_state_e          r_state;
    arb_state_e          w_state_nxt;
    logic                w_run;
    logic [ID_W-1:0]     r_ptr;
    logic [NUM_REQ-1:0]  w_gnt;
    logic [ID_W-1:0]     w_idx;
    logic                w_any;
    logic                w_hs;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [XLEN-1:0]     w_sel_data;
    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [XLEN-1:0]     r_wr_data;
    logic [ID_W-1:0]     r_wr_src;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= HOLD;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = HOLD;
        w_run       = 1'b0;
        case (r_state)
            HOLD: w_state_nxt = RUN;
            RUN: begin
                w_state_nxt = RUN;
                w_run       = 1'b1;
            end
            default: w_state_nxt = HOLD;
        endcase
    end

    rr_priority_pick #(.N(NUM_REQ), .IDW(ID_W)) u_pick (
        .i_req (req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    // Grant is a pure function of valid, pointer and state, never of payload.
    assign req_ready  = w_run ? w_gnt : '0;
    assign w_hs       = w_run && w_any;
    assign w_sel_addr = req_addr[w_idx*ADDR_W +: ADDR_W];
    assign w_sel_data = req_data[w_idx*XLEN +: XLEN];

    // x0 writes still load addr/data/src so the consumed request is visible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_wr_src  <= '0;
            r_ptr     <= '0;
        end else if (w_hs) begin
            r_wr_en   <= (w_sel_addr != '0);
            r_wr_addr <= w_sel_addr;
            r_wr_data <= w_sel_data;
            r_wr_src  <= w_idx;
            r_ptr     <= (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
        end else begin
            r_wr_en   <= 1'b0;
        end
    end

    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign wr_src  = r_wr_src;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed vector table, hand-written async-reset
// sequence, then random traffic against a behavioural round-robin model.
module tb_rf_write_arbiter;

    localparam int NR = 3;
    localparam int AW = 5;
    localparam int DW = 32;

    logic              clk;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic [1:0]        wr_src;

    rf_write_arbiter #(.NUM_REQ(NR), .XLEN(DW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_src    (wr_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit          m_hold;
    int          m_ptr;
    bit          m_en;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    int          m_src;
    logic [2:0]  last_rdy;

    typedef struct {
        logic [2:0]  valid;
        logic [14:0] addr;
        logic [95:0] data;
        logic [2:0]  rdy;
        logic        en;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [1:0]  src;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hold = 1; m_ptr = 0; m_en = 0; m_addr = '0; m_data = '0; m_src = 0;
    endtask

    function automatic logic [2:0] model_ready(input logic [2:0] v);
        logic [2:0] r;
        r = '0;
        if (m_hold || !rst) return r;
        for (int k = 0; k < NR; k++) begin
            if (v[(m_ptr + k) % NR]) begin
                r[(m_ptr + k) % NR] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    task automatic model_edge(input logic [14:0] a, input logic [95:0] d, input logic [2:0] rdy);
        if (m_hold) begin
            m_hold = 0;
            m_en   = 0;
        end else if (rdy == 3'b000) begin
            m_en = 0;
        end else begin
            int g;
            g = (rdy[0]) ? 0 : (rdy[1]) ? 1 : 2;
            m_addr = a[g*AW +: AW];
            m_data = d[g*DW +: DW];
            m_en   = (m_addr != 0);
            m_src  = g;
            m_ptr  = (g + 1) % NR;
        end
    endtask

    // Called just after a negedge; returns at the following negedge.
    task automatic step(input logic [2:0] v, input logic [14:0] a, input logic [95:0] d);
        logic [2:0] er;
        req_valid = v; req_addr = a; req_data = d;
        #1;
        er = model_ready(v);
        last_rdy = req_ready;
        chk("req_ready", 128'(req_ready), 128'(er));
        @(posedge clk);
        model_edge(a, d, er);
        #1;
        chk("wr_en",   128'(wr_en),   128'(m_en));
        chk("wr_addr", 128'(wr_addr), 128'(m_addr));
        chk("wr_data", 128'(wr_data), 128'(m_data));
        chk("wr_src",  128'(wr_src),  128'(m_src));
        @(negedge clk);
    endtask

    function automatic vec_t mk(input logic [2:0] v, input logic [14:0] a, input logic [95:0] d,
                                input logic [2:0] r, input logic e, input logic [4:0] wa,
                                input logic [31:0] wd, input logic [1:0] s);
        vec_t t;
        t.valid = v; t.addr = a; t.data = d; t.rdy = r;
        t.en = e; t.waddr = wa; t.wdata = wd; t.src = s;
        return t;
    endfunction

    task automatic mid_reset();
        rst = 1'b0;
        #1;
        chk("async_wr_en",   128'(wr_en),     128'(0));
        chk("async_wr_addr", 128'(wr_addr),   128'(0));
        chk("async_wr_data", 128'(wr_data),   128'(0));
        chk("async_ready",   128'(req_ready), 128'(0));
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [14:0] rr_a;
        logic [95:0] rr_d;
        rr_a = {5'd3, 5'd2, 5'd1};
        rr_d = {32'hC, 32'hB, 32'hA};

        tbl[0]  = mk(3'b111, rr_a, rr_d, 3'b000, 1'b0, 5'd0, 32'h0, 2'd0);
        tbl[1]  = mk(3'b111, rr_a, rr_d, 3'b001, 1'b1, 5'd1, 32'hA, 2'd0);
        tbl[2]  = mk(3'b111, rr_a, rr_d, 3'b010, 1'b1, 5'd2, 32'hB, 2'd1);
        tbl[3]  = mk(3'b111, rr_a, rr_d, 3'b100, 1'b1, 5'd3, 32'hC, 2'd2);
        tbl[4]  = mk(3'b111, rr_a, rr_d, 3'b001, 1'b1, 5'd1, 32'hA, 2'd0);
        tbl[5]  = mk(3'b111, rr_a, rr_d, 3'b010, 1'b1, 5'd2, 32'hB, 2'd1);
        tbl[6]  = mk(3'b111, rr_a, rr_d, 3'b100, 1'b1, 5'd3, 32'hC, 2'd2);
        // x0 write from requester 1: consumed, no enable, pointer -> 2
        tbl[7]  = mk(3'b010, 15'd0, {32'h0, 32'hDEADBEEF, 32'h0}, 3'b010, 1'b0, 5'd0, 32'hDEADBEEF, 2'd1);
        // pointer at 2, only requester 0 valid: wraps to 0
        tbl[8]  = mk(3'b001, {10'd0, 5'd7}, {64'h0, 32'h55}, 3'b001, 1'b1, 5'd7, 32'h55, 2'd0);
        tbl[9]  = mk(3'b010, {5'd0, 5'd9, 5'd0}, {32'h0, 32'h99, 32'h0}, 3'b010, 1'b1, 5'd9, 32'h99, 2'd1);
        tbl[10] = mk(3'b000, 15'd0, 96'd0, 3'b000, 1'b0, 5'd9, 32'h99, 2'd1);
        tbl[11] = mk(3'b000, 15'd0, 96'd0, 3'b000, 1'b0, 5'd9, 32'h99, 2'd1);
        tbl[12] = mk(3'b000, 15'd0, 96'd0, 3'b000, 1'b0, 5'd9, 32'h99, 2'd1);

        rst = 1'b0; req_valid = 3'b111; req_addr = rr_a; req_data = rr_d;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_en",   128'(wr_en),     128'(0));
        chk("rst_wr_addr", 128'(wr_addr),   128'(0));
        chk("rst_wr_data", 128'(wr_data),   128'(0));
        chk("rst_wr_src",  128'(wr_src),    128'(0));
        chk("rst_ready",   128'(req_ready), 128'(0));
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].valid, tbl[i].addr, tbl[i].data);
            chk($sformatf("tbl%0d_ready", i), 128'(last_rdy), 128'(tbl[i].rdy));
            chk($sformatf("tbl%0d_en", i),    128'(wr_en),    128'(tbl[i].en));
            chk($sformatf("tbl%0d_addr", i),  128'(wr_addr),  128'(tbl[i].waddr));
            chk($sformatf("tbl%0d_data", i),  128'(wr_data),  128'(tbl[i].wdata));
            chk($sformatf("tbl%0d_src", i),   128'(wr_src),   128'(tbl[i].src));
        end

        // Async reset while a write is on the port, then HOLD and restart at 0
        step(3'b111, rr_a, rr_d);
        chk("pre_rst_en", 128'(wr_en), 128'(1));
        #2;
        mid_reset();
        step(3'b111, rr_a, rr_d);
        chk("post_rst_hold", 128'(last_rdy), 128'(3'b000));
        step(3'b111, rr_a, rr_d);
        chk("post_rst_ready", 128'(last_rdy), 128'(3'b001));
        chk("post_rst_src",   128'(wr_src),   128'(0));
        chk("post_rst_en",    128'(wr_en),    128'(1));

        for (int n = 0; n < 600; n++) begin
            logic [14:0] a;
            logic [95:0] d;
            for (int j = 0; j < NR; j++) begin
                a[j*AW +: AW] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
                d[j*DW +: DW] = $urandom;
            end
            if (n % 151 == 150) mid_reset();
            step(3'($urandom_range(0, 7)), a, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
